// File: rtl/sr_icache.sv
// sr_icache: direct-mapped, read-only instruction cache with single-line burst refill.
// Define SR_ICACHE_STATS_EN to add saturating hit_cnt/miss_cnt statistics ports.

module sr_icache #(
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_drdy,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
`ifdef SR_ICACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W - 2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_FILL = 3'd3,
        RESP      = 3'd4
    } state_t;

    state_t state_r, state_s;

    logic [29:0]       word_addr_r;
    logic [31:0]       rdata_r;
    logic              mem_req_r;
    logic [31:0]       mem_addr_r;
    logic [OFF_W-1:0]  beat_r;
    logic [SETS-1:0]   valid_r;
    logic [31:0]       data_arr_r [SETS][LINE_WORDS];
    logic [TAG_W-1:0]  tag_arr_r  [SETS];

    logic [OFF_W-1:0]  off_s, new_off_s;
    logic [IDX_W-1:0]  idx_s, new_idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic              hit_s, grant_s, beat_s, last_beat_s;
    logic              accept_s, start_miss_s, lookup_hit_s, drdy_s;
    logic              unused_addr_s;

    assign off_s       = word_addr_r[OFF_W-1:0];
    assign idx_s       = word_addr_r[OFF_W+IDX_W-1:OFF_W];
    assign tag_s       = word_addr_r[29:OFF_W+IDX_W];
    assign new_off_s   = cpu_addr[OFF_W+1:2];
    assign new_idx_s   = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign unused_addr_s = ^cpu_addr[1:0];

    // A flush in the lookup cycle wins over a tag match, so that cycle becomes a miss.
    assign hit_s       = valid_r[idx_s] && (tag_arr_r[idx_s] == tag_s) && !flush;
    assign grant_s     = (state_r == MISS_REQ) && mem_gnt;
    assign beat_s      = (state_r == MISS_FILL) && mem_rvalid;
    assign last_beat_s = beat_s && (beat_r == OFF_W'(LINE_WORDS - 1));

    assign cpu_rdata = rdata_r;
    assign cpu_drdy  = drdy_s;
    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        start_miss_s = 1'b0;
        lookup_hit_s = 1'b0;
        drdy_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (cpu_req) begin
                    accept_s = 1'b1;
                    state_s  = LOOKUP;
                end else begin
                    state_s  = IDLE;
                end
            end
            LOOKUP: begin
                if (hit_s) begin
                    drdy_s       = 1'b1;
                    lookup_hit_s = 1'b1;
                    if (cpu_req) begin
                        accept_s = 1'b1;
                        state_s  = LOOKUP;
                    end else begin
                        state_s  = IDLE;
                    end
                end else begin
                    start_miss_s = 1'b1;
                    state_s      = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (mem_gnt) begin
                    state_s = MISS_FILL;
                end else begin
                    state_s = MISS_REQ;
                end
            end
            MISS_FILL: begin
                if (last_beat_s) begin
                    state_s = RESP;
                end else begin
                    state_s = MISS_FILL;
                end
            end
            RESP: begin
                drdy_s = 1'b1;
                if (cpu_req) begin
                    accept_s = 1'b1;
                    state_s  = LOOKUP;
                end else begin
                    state_s  = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Request address, response word, refill request and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_addr_r <= 30'd0;
            rdata_r     <= 32'd0;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= 32'd0;
            beat_r      <= {OFF_W{1'b0}};
        end else begin
            // The word is read at acceptance; the arrays cannot change before it is presented.
            if (accept_s) begin
                word_addr_r <= cpu_addr[31:2];
                rdata_r     <= data_arr_r[new_idx_s][new_off_s];
            end
            if (start_miss_s) begin
                mem_req_r  <= 1'b1;
                mem_addr_r <= {tag_s, idx_s, {(OFF_W + 2){1'b0}}};
            end
            if (grant_s) begin
                mem_req_r <= 1'b0;
                beat_r    <= {OFF_W{1'b0}};
            end
            if (beat_s) begin
                beat_r <= beat_r + 1'b1;
                if (beat_r == off_s) begin
                    rdata_r <= mem_rdata;
                end
            end
        end
    end

    // Valid bits: flush clears all, but a completing refill still marks its own line.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {SETS{1'b0}};
        end else begin
            if (flush) begin
                valid_r <= {SETS{1'b0}};
            end
            if (grant_s) begin
                valid_r[idx_s] <= 1'b0;
            end
            if (last_beat_s) begin
                valid_r[idx_s] <= 1'b1;
            end
        end
    end

    // Data and tag storage written by refill beats.
    always_ff @(posedge clk) begin
        if (beat_s && !rst) begin
            data_arr_r[idx_s][beat_r] <= mem_rdata;
        end
        if (last_beat_s && !rst) begin
            tag_arr_r[idx_s] <= tag_s;
        end
    end

`ifdef SR_ICACHE_STATS_EN
    logic [31:0] hit_cnt_r, miss_cnt_r;

    // Saturating lookup statistics, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_r  <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else begin
            if (lookup_hit_s && (hit_cnt_r != 32'hFFFF_FFFF)) begin
                hit_cnt_r <= hit_cnt_r + 32'd1;
            end
            if (start_miss_s && (miss_cnt_r != 32'hFFFF_FFFF)) begin
                miss_cnt_r <= miss_cnt_r + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_r;
    assign miss_cnt = miss_cnt_r;
`else
    logic unused_stats_s;
    assign unused_stats_s = lookup_hit_s;
`endif

endmodule

// File: tb/tb_sr_icache.sv
// Self-checking bench for sr_icache: directed scenarios plus random fetches against a
// set/tag presence model and an arithmetic backing memory.

module tb_sr_icache;

    localparam int LW = 4;
    localparam int NS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_drdy;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
`ifdef SR_ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int gnt_wait = 0;
    bit gap_mode = 1'b0;
    int beats_sent = 0;

    bit          mvalid [NS];
    int unsigned mtag   [NS];
    int          mhits = 0;
    int          mmiss = 0;

    sr_icache #(.LINE_WORDS(LW), .SETS(NS)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_rdata  (cpu_rdata),
        .cpu_drdy   (cpu_drdy),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
`ifdef SR_ICACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return 32'hA0 + (a >> 2);
    endfunction

    function automatic int unsigned set_of(input logic [31:0] a);
        int unsigned ua = a;
        return (ua / (LW * 4)) % NS;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        int unsigned ua = a;
        return ua / (LW * 4 * NS);
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        int unsigned ua = a;
        return (ua / (LW * 4)) * (LW * 4);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < NS; i++) mvalid[i] = 1'b0;
    endtask

    task automatic check_stats();
`ifdef SR_ICACHE_STATS_EN
        check("hit_cnt", hit_cnt, mhits);
        check("miss_cnt", miss_cnt, mmiss);
`endif
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_drdy"}, 32'(cpu_drdy), 32'd0);
        check({tag, "_rdata"}, cpu_rdata, 32'd0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
    endtask

    task automatic flush_idle();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        clear_model();
    endtask

    // mode 0: plain fetch, 1: flush during the lookup cycle, 2: flush during the refill
    task automatic fetch(input logic [31:0] a, input int mode);
        int unsigned s, t;
        bit  exp_hit, done;
        int  exp_lat, lat, grants;
        s = set_of(a);
        t = tag_of(a);
        exp_hit = (mode != 1) && mvalid[s] && (mtag[s] == t);
        if (mode == 1) clear_model();
        if (exp_hit) begin
            mhits++;
        end else begin
            mmiss++;
            if (mode == 2) clear_model();
            mvalid[s] = 1'b1;
            mtag[s]   = t;
        end
        exp_lat = exp_hit ? 1 : 3 + gnt_wait + (gap_mode ? 2 * LW - 1 : LW);

        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = a;
        @(posedge clk);
        lat = 0;
        grants = 0;
        done = 1'b0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            cpu_req = 1'b0;
            flush = (mode == 1 && lat == 1) || (mode == 2 && lat == 3 + gnt_wait);
            #1;
            if (mem_req) begin
                check("mem_addr", mem_addr, line_of(a));
                if (mem_gnt) grants++;
            end
            done = cpu_drdy;
        end
        flush = 1'b0;
        check("drdy_seen", 32'(done), 32'd1);
        check("latency", lat, exp_lat);
        check("rdata", cpu_rdata, mem_val(a & ~32'd3));
        check("refills", grants, exp_hit ? 32'd0 : 32'd1);
        check_stats();
    endtask

    // Burst memory: grant after gnt_wait cycles, then LW beats, optionally with 1-cycle gaps.
    initial begin : responder
        bit granted = 1'b0;
        bit active = 1'b0;
        bit skip = 1'b0;
        int wait_n = 0;
        int beat = 0;
        logic [31:0] base = 32'd0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (granted) begin
                granted = 1'b0;
                active = 1'b1;
                beat = 0;
                skip = 1'b0;
            end
            if (active) begin
                if (skip) begin
                    skip = 1'b0;
                end else begin
                    mem_rvalid = 1'b1;
                    mem_rdata = mem_val(base + 32'(4 * beat));
                    beat++;
                    beats_sent++;
                    skip = gap_mode;
                    if (beat == LW) active = 1'b0;
                end
            end else if (mem_req) begin
                if (wait_n < gnt_wait) begin
                    wait_n++;
                end else begin
                    mem_gnt = 1'b1;
                    granted = 1'b1;
                    wait_n = 0;
                    base = mem_addr;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] burst_a [3];
        logic [31:0] a;
        int base_beats, n, r;
        burst_a = '{32'h0, 32'h4, 32'hC};
        cpu_req = 1'b0;
        cpu_addr = 32'd0;
        flush = 1'b0;
        rst = 1'b1;
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        check_quiet("reset");
        check_stats();
        rst = 1'b0;

        // Cold miss: 0x8 with an immediate grant returns 0xA2 after 7 cycles.
        fetch(32'h8, 0);

        // Back-to-back hits on the refilled line.
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_addr = burst_a[0];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("burst_drdy", 32'(cpu_drdy), 32'd1);
            check("burst_rdata", cpu_rdata, mem_val(burst_a[k]));
            check("burst_no_mem_req", 32'(mem_req), 32'd0);
            mhits++;
            if (k < 2) cpu_addr = burst_a[k + 1];
            else cpu_req = 1'b0;
        end
        @(negedge clk);
        #1;
        check("burst_end_drdy", 32'(cpu_drdy), 32'd0);
        check_stats();

        // Conflict eviction on set 0.
        flush_idle();
        fetch(32'h0, 0);
        fetch(32'h100, 0);
        fetch(32'h0, 0);

        // Grant delay and gapped beats.
        gnt_wait = 3;
        gap_mode = 1'b1;
        fetch(32'h2C, 0);
        gnt_wait = 0;
        gap_mode = 1'b0;

        // Flush in idle, during a refill, and during a lookup.
        fetch(32'h40, 0);
        fetch(32'h44, 0);
        flush_idle();
        fetch(32'h40, 0);
        fetch(32'h80, 2);
        fetch(32'h84, 0);
        fetch(32'h48, 0);
        fetch(32'h88, 1);

        // Reset after two of four beats; the remaining beats arrive as strays.
        gap_mode = 1'b1;
        base_beats = beats_sent;
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_addr = 32'hC0;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        n = 0;
        while (beats_sent - base_beats < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_two_beats", beats_sent - base_beats, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        clear_model();
        mhits = 0;
        mmiss = 0;
        check_quiet("rst_mid");
        repeat (4) @(negedge clk);
        #1;
        check_quiet("rst_stray");
        check("rst_stray_beats", beats_sent - base_beats, 32'd4);
        check_stats();
        gap_mode = 1'b0;
        fetch(32'hC4, 0);
        fetch(32'h8, 0);

        // Random fetches over a few sets and tags.
        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 2)) * 32'(LW * 4 * NS)
              + 32'($urandom_range(0, 3)) * 32'(LW * 4)
              + 32'($urandom_range(0, LW - 1)) * 32'd4
              + 32'($urandom_range(0, 3));
            gnt_wait = $urandom_range(0, 3);
            gap_mode = ($urandom_range(0, 1) == 1);
            r = $urandom_range(0, 9);
            if (r == 0) flush_idle();
            fetch(a, (r == 1) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sr_icache.md
# sr_icache

Direct-mapped, read-only instruction cache between the schoolRISCV core's instruction fetch port and a slower burst-capable instruction memory. Returns one 32-bit instruction per cycle on a hit. On a miss, stalls the core, refills one full line from memory, then returns the requested word. Optionally keeps hit/miss statistics for benchmarking fetch behaviour.

## Interface
- `LINE_WORDS`, 4: 32-bit words per line; power of 2, ≥2.
- `SETS`, 16: number of lines; power of 2, ≥2.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; one clock, reset is synchronous and active-high.
- `cpu_req` in 1: fetch request valid.
- `cpu_addr` in 32: byte address; bits [1:0] ignored.
- `cpu_rdata` out 32: instruction word; valid when `cpu_drdy`=1.
- `cpu_drdy` out 1: one-cycle pulse; `cpu_rdata` belongs to the last accepted address.
- `flush` in 1: invalidate all lines.
- `mem_req` out 1: line-refill request; held until `mem_gnt`.
- `mem_addr` out 32: line-aligned byte address of the refill.
- `mem_gnt` in 1: request accepted on an edge where `mem_req`=`mem_gnt`=1.
- `mem_rdata` in 32: refill beat data.
- `mem_rvalid` in 1: beat valid; beats arrive in order word 0..LINE_WORDS-1, gaps allowed.
- `hit_cnt` out 32, `miss_cnt` out 32: present only with `SR_ICACHE_STATS_EN`.

## Operation
- Address split: offset = `addr[OFF+1:2]` (OFF=log2 LINE_WORDS), index = next log2(SETS) bits, tag = the remaining upper bits.
- Storage: data array SETS×LINE_WORDS×32, tag array, valid bit per set.
- FSM states: IDLE, LOOKUP, MISS_REQ, MISS_FILL, RESP.
- IDLE: if `cpu_req`, register address → LOOKUP.
- LOOKUP: compare tag and valid for the registered index.
  - Hit: `cpu_drdy`=1 with the cached word. If `cpu_req`, accept the new address and stay in LOOKUP; otherwise go to IDLE.
  - Miss: no acceptance → MISS_REQ.
- MISS_REQ: `mem_req`=1, `mem_addr`={tag,index,OFF+2 zero bits}. On `mem_gnt` → MISS_FILL with beat counter = 0.
- MISS_FILL: each `mem_rvalid` writes `mem_rdata` into word [counter] of the line. When the word equals the requested offset, it is also captured to the response register. The counter increments and wraps at LINE_WORDS. After the last beat, write the tag, set valid → RESP.
- RESP: `cpu_drdy`=1 with the captured word. `cpu_req` is handled as in a LOOKUP hit (accept → LOOKUP, else → IDLE).
- `cpu_req` is ignored in MISS_REQ and MISS_FILL. The core holds its address while `cpu_drdy`=0.
- `flush`: clears all valid bits at the edge.
  - If in LOOKUP, that cycle is treated as a miss.
  - If in MISS_*, the refill completes and its line is written valid.
- `mem_rvalid` outside MISS_FILL is ignored.

## Timing
- Reset values: state IDLE; all valid bits 0; `cpu_drdy`=0, `cpu_rdata`=0, `mem_req`=0, `mem_addr`=0, counters 0.
- Hit latency: address accepted at edge N → `cpu_drdy` high in the cycle after edge N.
- Back-to-back hits: throughput of 1 word/cycle.
- Miss latency, from acceptance to `cpu_drdy`: 1 (lookup) + 1 (MISS_REQ entry) + grant wait + beats including gaps + 1 (RESP). With zero-wait memory and LINE_WORDS=4, `cpu_drdy` arrives 7 cycles after acceptance.
- `rst` mid-refill: aborts to IDLE; the line stays invalid; remaining beats are ignored.
- `mem_addr` is stable while `mem_req`=1.

## Configuration
- `SR_ICACHE_STATS_EN` defined:
  - `hit_cnt` increments on each LOOKUP hit; `miss_cnt` increments on each LOOKUP miss.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by `rst` only.
- `SR_ICACHE_STATS_EN` not defined: the ports and counters do not exist; all other behaviour is identical.

## Test plan
- Cold miss, LINE_WORDS=4: request 0x0000_0008, memory grants immediately and returns 0xA0..0xA3 → one `mem_req` with `mem_addr`=0x0; `cpu_rdata`=0xA2 at cycle 7; `miss_cnt`=1.
- Sequential hits: after that refill, requests 0x0, 0x4, 0xC on consecutive cycles → `cpu_drdy` on 3 consecutive cycles with data 0xA0, 0xA1, 0xA3; no `mem_req`; `hit_cnt`=3.
- Conflict eviction, SETS=16: fetch 0x0, then 0x100 (same index, different tag), then 0x0 again → three refills; the last one returns the original line data.
- Beat gaps and grant delay: `mem_gnt` held low for 3 cycles, `mem_rvalid` toggled 1,0,1,0,… → correct word returned; `mem_addr` is stable during the wait.
- Flush: the line at 0x40 is cached, `flush` is pulsed, then 0x40 is requested → miss and refill. `flush` asserted during a MISS_FILL → that line is still valid afterwards.
- Reset mid-refill: `rst` asserted after 2 of 4 beats, then 2 stray `mem_rvalid` beats → IDLE, outputs 0, next request to the same line misses.
